lc4_multiplier_seq: RTL and testbench

- Multi-cycle shift-add multiply-accumulate unit: computes i_multiplicand * i_multiplier + i_addend, keeping the low 16 bits as the LC4 MUL result.
- Inverse of the divider: feeding (quotient, divisor, remainder) reconstructs the dividend. The divider-consistency bench uses it, as does the pipeline's multi-cycle MUL path.
- Start/done handshake; fixed, parameter-determined latency.

---
 rtl/lc4_multiplier_seq_if.sv | 22 ++
 rtl/lc4_multiplier_seq.sv | 111 +++++++++++
 tb/tb_lc4_multiplier_seq.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/lc4_multiplier_seq_if.sv
// Handshake and operand/result bundle for the LC4 sequential multiply-accumulate unit.
// The master modport belongs to the requester and the slave modport to the multiplier.
interface lc4_multiplier_seq_if;
  logic        i_start;
  logic [15:0] i_multiplicand;
  logic [15:0] i_multiplier;
  logic [15:0] i_addend;
  logic        o_ready;
  logic        o_valid;
  logic [15:0] o_product;
  logic        o_overflow;

  modport master (
    output i_start, i_multiplicand, i_multiplier, i_addend,
    input  o_ready, o_valid, o_product, o_overflow
  );

  modport slave (
    input  i_start, i_multiplicand, i_multiplier, i_addend,
    output o_ready, o_valid, o_product, o_overflow
  );
endinterface

// File: rtl/lc4_multiplier_seq.sv
// Multi-cycle shift-add multiply-accumulate: product = low 16 bits of A*B+C, with an overflow flag.
// Retires BITS_PER_CYCLE multiplier bits per BUSY cycle, so the latency is fixed at 16/BITS_PER_CYCLE.
module lc4_multiplier_seq #(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  lc4_multiplier_seq_if.slave  bus
);
  localparam int LATENCY = 16 / BITS_PER_CYCLE;

  generate
    if (BITS_PER_CYCLE != 1 && BITS_PER_CYCLE != 2 && BITS_PER_CYCLE != 4 &&
        BITS_PER_CYCLE != 8 && BITS_PER_CYCLE != 16) begin : g_bad_bits_per_cycle
      $error("lc4_multiplier_seq: BITS_PER_CYCLE must be 1, 2, 4, 8 or 16");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t      state_r;
  state_t      state_nxt_s;
  logic [31:0] mcand_r;     // multiplicand pre-shifted to the current bit position
  logic [15:0] mplier_r;    // multiplier with retired bits shifted out
  logic [31:0] acc_r;
  logic [31:0] acc_nxt_s;
  logic [4:0]  count_r;
  logic [15:0] product_r;
  logic        overflow_r;
  logic        accept_s;
  logic        last_s;

  assign accept_s = (state_r != ST_BUSY) && bus.i_start;
  assign last_s   = (state_r == ST_BUSY) && (count_r == 5'(LATENCY - 1));

  // Partial-product sum for the bits retired this cycle.
  always_comb begin
    acc_nxt_s = acc_r;
    for (int k = 0; k < BITS_PER_CYCLE; k++) begin
      if (mplier_r[k]) begin
        acc_nxt_s = acc_nxt_s + (mcand_r << k);
      end else begin
        acc_nxt_s = acc_nxt_s;
      end
    end
  end

  // Next-state decode; DONE accepts a new start just like IDLE.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) state_nxt_s = ST_BUSY;
        else          state_nxt_s = ST_IDLE;
      end
      ST_BUSY: begin
        if (last_s) state_nxt_s = ST_DONE;
        else        state_nxt_s = ST_BUSY;
      end
      ST_DONE: begin
        if (accept_s) state_nxt_s = ST_BUSY;
        else          state_nxt_s = ST_IDLE;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Operand capture, shift-add iteration and held result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_r    <= 32'd0;
      mplier_r   <= 16'd0;
      acc_r      <= 32'd0;
      count_r    <= 5'd0;
      product_r  <= 16'd0;
      overflow_r <= 1'b0;
    end else if (accept_s) begin
      mcand_r  <= {16'd0, bus.i_multiplicand};
      mplier_r <= bus.i_multiplier;
      acc_r    <= {16'd0, bus.i_addend};
      count_r  <= 5'd0;
    end else if (state_r == ST_BUSY) begin
      acc_r    <= acc_nxt_s;
      mcand_r  <= mcand_r << BITS_PER_CYCLE;
      mplier_r <= mplier_r >> BITS_PER_CYCLE;
      count_r  <= count_r + 5'd1;
      if (last_s) begin
        product_r  <= acc_nxt_s[15:0];
        overflow_r <= |acc_nxt_s[31:16];
      end
    end
  end

  assign bus.o_ready    = (state_r != ST_BUSY);
  assign bus.o_valid    = (state_r == ST_DONE);
  assign bus.o_product  = product_r;
  assign bus.o_overflow = overflow_r;
endmodule

// File: tb/tb_lc4_multiplier_seq.sv
// Randomized self-checking bench for lc4_multiplier_seq: a countdown-based reference model is compared
// every cycle against the 1-bit/cycle instance; a 4-bit/cycle instance gets directed and arithmetic checks.
module tb_lc4_multiplier_seq;
  localparam int N  = 16;
  localparam int N4 = 4;

  logic clk;
  logic rst_n;
  int   passes;
  int   total;
  bit   chk_en;

  lc4_multiplier_seq_if bus ();
  lc4_multiplier_seq_if bus4 ();

  lc4_multiplier_seq #(.BITS_PER_CYCLE(1)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  lc4_multiplier_seq #(.BITS_PER_CYCLE(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end else begin
      passes++;
    end
  endtask

  // Reference model: an accepted start yields A*B+C exactly N edges later.
  int     m_left;
  longint m_exp;
  logic   m_valid;
  logic [15:0] m_prod;
  logic   m_ovf;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left  <= 0;
      m_exp   <= 0;
      m_valid <= 1'b0;
      m_prod  <= 16'h0000;
      m_ovf   <= 1'b0;
    end else begin
      m_valid <= 1'b0;
      if (m_left == 0 && bus.i_start) begin
        m_left <= N;
        m_exp  <= longint'(bus.i_multiplicand) * longint'(bus.i_multiplier) + longint'(bus.i_addend);
      end else if (m_left > 0) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_valid <= 1'b1;
          m_prod  <= m_exp[15:0];
          m_ovf   <= (m_exp > 64'd65535);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("x_out", 32'($isunknown({bus.o_ready, bus.o_valid, bus.o_product, bus.o_overflow})), 32'd0);
      chk("ready", 32'(bus.o_ready), 32'(m_left == 0));
      chk("valid", 32'(bus.o_valid), 32'(m_valid));
      chk("product", 32'(bus.o_product), 32'(m_prod));
      chk("overflow", 32'(bus.o_overflow), 32'(m_ovf));
    end
  end

  // Starts an operation at the current negedge and returns at the negedge where o_valid is seen.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c,
                        input bit inject, input int idle,
                        output logic [15:0] prod, output logic ovf);
    int cyc;
    repeat (idle) @(negedge clk);
    bus.i_start = 1'b1;
    bus.i_multiplicand = a;
    bus.i_multiplier = b;
    bus.i_addend = c;
    cyc = 0;
    while (cyc < 40 && !(cyc > 0 && bus.o_valid)) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1 || (inject && cyc == 6)) begin
        bus.i_start = 1'b0;
        bus.i_multiplicand = 16'($urandom);
        bus.i_multiplier = 16'($urandom);
        bus.i_addend = 16'($urandom);
      end
      if (inject && cyc == 5) begin
        bus.i_start = 1'b1;
        bus.i_multiplicand = 16'($urandom);
        bus.i_multiplier = 16'($urandom);
        bus.i_addend = 16'($urandom);
      end
    end
    chk("latency", 32'(cyc), 32'(N + 1));
    prod = bus.o_product;
    ovf = bus.o_overflow;
  endtask

  task automatic run4(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
    int cyc;
    longint e;
    e = longint'(a) * longint'(b) + longint'(c);
    bus4.i_start = 1'b1;
    bus4.i_multiplicand = a;
    bus4.i_multiplier = b;
    bus4.i_addend = c;
    cyc = 0;
    while (cyc < 20 && !(cyc > 0 && bus4.o_valid)) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) bus4.i_start = 1'b0;
      if (cyc > 1 && cyc <= N4) chk("bpc4_busy_ready", 32'(bus4.o_ready), 32'd0);
    end
    chk("bpc4_latency", 32'(cyc), 32'(N4 + 1));
    chk("bpc4_product", 32'(bus4.o_product), 32'(e[15:0]));
    chk("bpc4_overflow", 32'(bus4.o_overflow), 32'(e > 64'd65535));
    @(negedge clk);
    chk("bpc4_valid_pulse", 32'(bus4.o_valid), 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", passes, total);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] p;
    logic        o;
    logic [15:0] dividend, divisor, q, r;
    int          stray;
    passes = 0;
    total = 0;
    chk_en = 1'b0;
    rst_n = 1'b0;
    bus.i_start = 1'b0;
    bus.i_multiplicand = 16'h0000;
    bus.i_multiplier = 16'h0000;
    bus.i_addend = 16'h0000;
    bus4.i_start = 1'b0;
    bus4.i_multiplicand = 16'h0000;
    bus4.i_multiplier = 16'h0000;
    bus4.i_addend = 16'h0000;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(bus.o_ready), 32'd1);
    chk("rst_valid", 32'(bus.o_valid), 32'd0);
    chk("rst_product", 32'(bus.o_product), 32'h0000);
    chk("rst_overflow", 32'(bus.o_overflow), 32'd0);
    rst_n = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);

    run_op(16'h0007, 16'h0006, 16'h0005, 1'b0, 1, p, o);
    chk("basic_product", 32'(p), 32'h002F);
    chk("basic_overflow", 32'(o), 32'd0);
    chk("model_pin_basic", 32'(m_prod), 32'h002F);

    run_op(16'h0036, 16'h0056, 16'h0010, 1'b0, 2, p, o);
    chk("divinv_product", 32'(p), 32'h1234);
    chk("divinv_overflow", 32'(o), 32'd0);
    chk("model_pin_divinv", 32'(m_prod), 32'h1234);

    run_op(16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b0, 1, p, o);
    chk("sat_all_product", 32'(p), 32'h0000);
    chk("sat_all_overflow", 32'(o), 32'd1);
    chk("model_pin_sat", 32'(m_ovf), 32'd1);

    run_op(16'h0100, 16'h0100, 16'h0000, 1'b0, 0, p, o);
    chk("sat_shift_product", 32'(p), 32'h0000);
    chk("sat_shift_overflow", 32'(o), 32'd1);

    run_op(16'h0000, 16'hBEEF, 16'h1357, 1'b0, 1, p, o);
    chk("zero_a_product", 32'(p), 32'h1357);
    chk("zero_a_overflow", 32'(o), 32'd0);
    run_op(16'hBEEF, 16'h0000, 16'h00AA, 1'b0, 0, p, o);
    chk("zero_b_product", 32'(p), 32'h00AA);

    run_op(16'h0007, 16'h0009, 16'h0003, 1'b1, 1, p, o);
    chk("busy_start_ignored", 32'(p), 32'h0042);
    run_op(16'h0011, 16'h0002, 16'h0000, 1'b0, 0, p, o);
    chk("back_to_back", 32'(p), 32'h0022);

    // Reset in the middle of an operation, between clock edges.
    bus.i_start = 1'b1;
    bus.i_multiplicand = 16'h1111;
    bus.i_multiplier = 16'h0003;
    bus.i_addend = 16'h0000;
    @(negedge clk);
    bus.i_start = 1'b0;
    repeat (7) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_ready", 32'(bus.o_ready), 32'd1);
    chk("midrst_valid", 32'(bus.o_valid), 32'd0);
    chk("midrst_product", 32'(bus.o_product), 32'h0000);
    chk("midrst_overflow", 32'(bus.o_overflow), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    stray = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (bus.o_valid) stray++;
    end
    chk("no_stray_valid", 32'(stray), 32'd0);
    run_op(16'h0123, 16'h0010, 16'h0004, 1'b0, 0, p, o);
    chk("post_rst_product", 32'(p), 32'h1234);

    for (int i = 0; i < 1000; i++) begin
      dividend = 16'($urandom);
      divisor = 16'($urandom_range(1, 65535));
      q = dividend / divisor;
      r = dividend % divisor;
      run_op(q, divisor, r, ($urandom_range(0, 7) == 0), $urandom_range(0, 2), p, o);
      chk("divinv_rand_product", 32'(p), 32'(dividend));
      chk("divinv_rand_overflow", 32'(o), 32'd0);
    end

    for (int i = 0; i < 150; i++) begin
      run_op(16'($urandom), 16'($urandom), 16'($urandom), 1'b0, $urandom_range(0, 1), p, o);
    end

    repeat (3) @(negedge clk);
    run4(16'h1234, 16'h0003, 16'h0001);
    chk("bpc4_pin", 32'(bus4.o_product), 32'h369D);
    run4(16'hFFFF, 16'hFFFF, 16'hFFFF);
    chk("bpc4_sat_pin", 32'({bus4.o_overflow, bus4.o_product}), 32'h10000);
    for (int i = 0; i < 40; i++) begin
      run4(16'($urandom), 16'($urandom), 16'($urandom));
    end

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
